qspi_bus_arbiter: RTL
=====================

Name: qspi_bus_arbiter

Overview:
- Shares the fast-domain register bus (addr/wdata/wen/ren/rdata/rvalid) between NREQ requesters, e.g. the QSPI host path and an on-chip debug/DMA engine.
- Issues one transaction at a time and tracks the single outstanding read, so read data is routed back to its owner.
- Arbitration is round-robin.
- A read-timeout watchdog releases the bus if the target never returns rvalid.

Parameters:
NREQ, 2, number of requesters (>=2)
DW, 16, data width
AW, 22, address width
TW, 8, timeout counter width
RD_TIMEOUT, 255, WAIT_RD cycles before the read is abandoned; 0 disables timeout

Ports:
clk  in  1  single clock
rst_n  in  1  synchronous, active-low reset
req_wen  in  NREQ  per-requester write request, level, held until granted
req_ren  in  NREQ  per-requester read request, level, held until granted
req_addr  in  NREQ*AW  packed addresses, requester i at [i*AW +: AW]
req_wdata  in  NREQ*DW  packed write data, requester i at [i*DW +: DW]
req_gnt  out  NREQ  one-cycle grant pulse; the requester may drop or change its request on the next cycle
req_rdata  out  DW  returned read data, shared
req_rvalid  out  NREQ  one-cycle pulse to the read owner; req_rdata is valid in that cycle
req_rerr  out  NREQ  one-cycle pulse to the read owner on timeout
addr  out  AW  bus address, registered
wdata  out  DW  bus write data, registered
wen  out  1  bus write strobe, one cycle
ren  out  1  bus read strobe, one cycle
rdata  in  DW  bus read data
rvalid  in  1  bus read data valid
busy  out  1  high when state != IDLE

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, rr pointer=0, timeout counter=0.
  - All outputs 0: addr, wdata, wen, ren, req_gnt, req_rvalid, req_rerr, req_rdata, busy.
  - Reset mid-read abandons the read. A late rvalid after reset is ignored (arrives in IDLE).
- States: IDLE, ISSUE, WAIT_RD.
- IDLE:
  - A requester is eligible if req_wen[i] | req_ren[i].
  - Winner = first eligible index scanning ptr, ptr+1, …, wrapping mod NREQ.
  - On a winner at edge T:
    - addr/wdata latch from the winner's slice.
    - wen <= req_wen[w]; ren <= req_ren[w] & ~req_wen[w] (write wins if both are set; the read is dropped for that grant).
    - req_gnt[w] <= 1.
    - ptr <= (w+1) mod NREQ, with wrap from NREQ-1 to 0.
    - owner <= w; state <= ISSUE.
  - No eligible requester: outputs stay idle (strobes 0, addr/wdata hold).
- ISSUE (exactly 1 cycle; wen/ren/req_gnt high during it):
  - No arbitration in this state.
  - Next edge: strobes and req_gnt return to 0.
  - Write: state <= IDLE. Write throughput is therefore 1 per 2 cycles.
  - Read: state <= WAIT_RD, counter <= 0.
  - An rvalid seen during ISSUE is ignored. Target read latency must be >=1 cycle after ren.
- WAIT_RD:
  - rvalid=1: req_rdata <= rdata, req_rvalid[owner] <= 1 for one cycle, state <= IDLE.
  - rvalid=0, RD_TIMEOUT!=0, and counter==RD_TIMEOUT-1: req_rerr[owner] <= 1 for one cycle, req_rdata holds, state <= IDLE.
  - Otherwise counter <= counter+1, saturating at the TW max.
  - If rvalid and timeout coincide, rvalid wins and no rerr is raised.
  - Arbitration resumes in the IDLE cycle after return. Requests held during WAIT_RD wait; there is no starvation because the rr pointer has already advanced.
- Stray rvalid in IDLE or ISSUE is ignored and produces no req_rvalid.
- Latency:
  - Request visible at edge T → bus strobe and gnt during cycle T+1.
  - rvalid sampled at edge R → req_rvalid during cycle R+1.
- busy is registered and equal to (state != IDLE).

Test Plan:
- Single write: req_wen[0]=1, req_addr slice0=22'h00123, wdata 16'hBEEF, held until gnt → one cycle later wen=1, addr=22'h00123, wdata=16'hBEEF, req_gnt=2'b01, busy=1 for 1 cycle; no further wen once the request drops.
- Fairness: both requesters hold writes continuously → req_gnt sequence 01,00,10,00,01,00,10 (grant every 2 cycles, alternating); wen high every other cycle.
- Read routing: req_ren[1]=1, addr 22'h3FFFFF; testbench returns rvalid 3 cycles after ren with rdata 16'hA5A5 → req_rvalid=2'b10 one cycle after rvalid with req_rdata=16'hA5A5. A write held on req0 meanwhile is granted only in the IDLE cycle after return.
- Timeout: RD_TIMEOUT=8, req_ren[0] granted, rvalid never asserted → req_rerr=2'b01 pulse after 8 WAIT_RD cycles, busy drops. An rvalid injected 2 cycles later produces no req_rvalid, and the next grant goes to req1.
- Reset mid-read: rst_n=0 in the 2nd WAIT_RD cycle, released, then rvalid=1 with 16'h1234 → no req_rvalid; all outputs 0; ptr restarts at 0, so simultaneous requests from 0 and 1 grant req0 first.
- Conflict: req_wen[0]=req_ren[0]=1 → single ISSUE cycle with wen=1, ren=0, then straight to IDLE (no WAIT_RD).

Source files
------------

// File: rtl/qspi_bus_arbiter.sv
// qspi_bus_arbiter: round-robin sharing of the fast-domain register bus
// between NREQ requesters. One transaction is in flight at a time, and the
// single outstanding read is routed back to its owner. A watchdog abandons
// reads whose rvalid never arrives.
module qspi_bus_arbiter #(
  parameter int NREQ       = 2,
  parameter int DW         = 16,
  parameter int AW         = 22,
  parameter int TW         = 8,
  parameter int RD_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_wen,
  input  logic [NREQ-1:0]      req_ren,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_wdata,
  output logic [NREQ-1:0]      req_gnt,
  output logic [DW-1:0]        req_rdata,
  output logic [NREQ-1:0]      req_rvalid,
  output logic [NREQ-1:0]      req_rerr,
  output logic [AW-1:0]        addr,
  output logic [DW-1:0]        wdata,
  output logic                 wen,
  output logic                 ren,
  input  logic [DW-1:0]        rdata,
  input  logic                 rvalid,
  output logic                 busy
);

  localparam int          PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned NR = NREQ;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     owner_q, owner_d;
  logic [TW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic              wen_q, wen_d;
  logic              ren_q, ren_d;
  logic              busy_q, busy_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   rvalid_q, rvalid_d;
  logic [NREQ-1:0]   rerr_q, rerr_d;

  logic              win_found;
  logic [PW-1:0]     win_idx;
  logic [PW-1:0]     cand_idx;
  int unsigned       cand;

  // Round-robin pick: first eligible requester scanning from ptr upward with wrap.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned k = 0; k < NR; k++) begin
      cand     = (32'(ptr_q) + k) % NR;
      cand_idx = PW'(cand);
      if (!win_found && (req_wen[cand_idx] || req_ren[cand_idx])) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // Next-state and next-output computation for the IDLE/ISSUE/WAIT_RD sequence.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    wen_d    = 1'b0;
    ren_d    = 1'b0;
    gnt_d    = '0;
    rvalid_d = '0;
    rerr_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          addr_d         = req_addr[32'(win_idx)*AW +: AW];
          wdata_d        = req_wdata[32'(win_idx)*DW +: DW];
          wen_d          = req_wen[win_idx];
          // A write request shadows a simultaneous read from the same requester.
          ren_d          = req_ren[win_idx] & ~req_wen[win_idx];
          gnt_d[win_idx] = 1'b1;
          ptr_d          = (32'(win_idx) == NR - 1) ? '0 : win_idx + 1'b1;
          owner_d        = win_idx;
          state_d        = ISSUE;
        end
      end
      ISSUE: begin
        if (ren_q) begin
          state_d = WAIT_RD;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_RD: begin
        if (rvalid) begin
          rdata_d           = rdata;
          rvalid_d[owner_q] = 1'b1;
          state_d           = IDLE;
        end else if ((RD_TIMEOUT != 0) && (cnt_q == TW'(RD_TIMEOUT - 1))) begin
          rerr_d[owner_q] = 1'b1;
          state_d         = IDLE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Register all state and outputs; synchronous active-low reset clears everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      wen_q    <= 1'b0;
      ren_q    <= 1'b0;
      busy_q   <= 1'b0;
      gnt_q    <= '0;
      rvalid_q <= '0;
      rerr_q   <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      wen_q    <= wen_d;
      ren_q    <= ren_d;
      busy_q   <= busy_d;
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      rerr_q   <= rerr_d;
    end
  end

  assign addr       = addr_q;
  assign wdata      = wdata_q;
  assign wen        = wen_q;
  assign ren        = ren_q;
  assign busy       = busy_q;
  assign req_gnt    = gnt_q;
  assign req_rdata  = rdata_q;
  assign req_rvalid = rvalid_q;
  assign req_rerr   = rerr_q;

endmodule
